fir_sequencer: RTL

//  Sequences one FIR run over sample memory, in the clk_b domain of the control registers.
//  A rising edge on Start launches the run. The block latches Ile_wsp taps and Ile_probek samples.
//  For each sample it drives coefficient/sample read addresses and MAC clear/enable, then writes the result.
//  It reports Pracuje (busy) and DONE back to the register file.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_tap_addr_gen.sv | 27 ++
 rtl/fir_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR run sequencer.
// Ports: none (package). Holds the sequencer state encoding, default widths and
// control-register index constants used by the register file.
package fir_pkg;

  localparam int WSP_W_DEF   = 6;
  localparam int PRB_W_DEF   = 14;
  localparam int MAC_LAT_DEF = 2;

  // Control register indices.
  localparam int START      = 0;
  localparam int DONE       = 1;
  localparam int PRACUJE    = 2;
  localparam int ILE_WSP    = 3;
  localparam int ILE_PROBEK = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    TAP,
    DRAIN,
    WRITE,
    FINISH
  } seq_state_t;

endpackage

// File: rtl/fir_tap_addr_gen.sv
// Per-tap address generator: coefficient address k, sample address n-k (wrapping),
// pre-history flag (k>n) and last-tap flag (k==W-1). Purely combinational.
// Ports: k_i, n_i, w_i in; coef_addr_o, smp_addr_o, mac_zero_o, last_tap_o out.
module fir_tap_addr_gen #(
  parameter int WSP_W = fir_pkg::WSP_W_DEF,
  parameter int PRB_W = fir_pkg::PRB_W_DEF
) (
  input  logic [WSP_W-1:0] k_i,
  input  logic [PRB_W-1:0] n_i,
  input  logic [WSP_W-1:0] w_i,
  output logic [WSP_W-1:0] coef_addr_o,
  output logic [PRB_W-1:0] smp_addr_o,
  output logic             mac_zero_o,
  output logic             last_tap_o
);
  import fir_pkg::*;

  // Common width so the k>n compare is correct whichever counter is wider.
  localparam int CW = (WSP_W > PRB_W) ? WSP_W : PRB_W;

  assign coef_addr_o = k_i;
  // Wraps modulo 2^PRB_W when k>n; mac_zero_o masks those reads.
  assign smp_addr_o  = n_i - PRB_W'(k_i);
  assign mac_zero_o  = CW'(k_i) > CW'(n_i);
  assign last_tap_o  = (k_i == w_i - 1'b1);

endmodule

// File: rtl/fir_sequencer.sv
// FIR run sequencer: on a Start rising edge latches tap/sample counts, then per
// sample issues MAC clear, W tap reads, MAC_LAT drain cycles and a result write.
// Ports: clk_b, rst_n, Start, Ile_wsp, Ile_probek in; Pracuje, DONE, coef_addr,
// smp_addr, mac_clr, mac_en, mac_zero, res_wr, res_addr out (all registered).
module fir_sequencer #(
  parameter int WSP_W   = fir_pkg::WSP_W_DEF,
  parameter int PRB_W   = fir_pkg::PRB_W_DEF,
  parameter int MAC_LAT = fir_pkg::MAC_LAT_DEF
) (
  input  logic             clk_b,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WSP_W-1:0] Ile_wsp,
  input  logic [PRB_W-1:0] Ile_probek,
  output logic             Pracuje,
  output logic             DONE,
  output logic [WSP_W-1:0] coef_addr,
  output logic [PRB_W-1:0] smp_addr,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             mac_zero,
  output logic             res_wr,
  output logic [PRB_W-1:0] res_addr
);
  import fir_pkg::*;

  localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  seq_state_t       state_q, state_d;
  logic             start_q;
  logic [WSP_W-1:0] wsp_q, wsp_d;
  logic [PRB_W-1:0] prb_q, prb_d;
  logic [WSP_W-1:0] k_q, k_d;
  logic [PRB_W-1:0] n_q, n_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             last_tap_q, last_tap_d;

  logic             pracuje_q, pracuje_d;
  logic             done_q, done_d;
  logic [WSP_W-1:0] coef_addr_q, coef_addr_d;
  logic [PRB_W-1:0] smp_addr_q, smp_addr_d;
  logic             mac_clr_q, mac_clr_d;
  logic             mac_en_q, mac_en_d;
  logic             mac_zero_q, mac_zero_d;
  logic             res_wr_q, res_wr_d;
  logic [PRB_W-1:0] res_addr_q, res_addr_d;

  logic             launch;
  logic [WSP_W-1:0] gen_coef;
  logic [PRB_W-1:0] gen_smp;
  logic             gen_zero;
  logic             gen_last;

  assign launch = Start & ~start_q;

  // Fed with next-state counters so every output can be registered alongside the state.
  fir_tap_addr_gen #(
    .WSP_W (WSP_W),
    .PRB_W (PRB_W)
  ) u_addr_gen (
    .k_i         (k_d),
    .n_i         (n_d),
    .w_i         (wsp_q),
    .coef_addr_o (gen_coef),
    .smp_addr_o  (gen_smp),
    .mac_zero_o  (gen_zero),
    .last_tap_o  (gen_last)
  );

  always_comb begin
    state_d = state_q;
    wsp_d   = wsp_q;
    prb_d   = prb_q;
    k_d     = k_q;
    n_d     = n_q;
    drain_d = drain_q;
    done_d  = done_q;

    unique case (state_q)
      IDLE: begin
        if (launch) begin
          wsp_d  = Ile_wsp;
          prb_d  = Ile_probek;
          done_d = 1'b0;
          n_d    = '0;
          k_d    = '0;
          if (Ile_wsp == '0 || Ile_probek == '0) state_d = FINISH;
          else                                   state_d = CLEAR;
        end
      end
      CLEAR: begin
        k_d     = '0;
        state_d = TAP;
      end
      TAP: begin
        // last_tap_q describes the tap being issued this cycle.
        if (last_tap_q) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRN_W'(MAC_LAT - 1)) state_d = WRITE;
        else                                drain_d = drain_q + 1'b1;
      end
      WRITE: begin
        if (n_q == prb_q - 1'b1) begin
          state_d = FINISH;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = CLEAR;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pracuje_d   = (state_d != IDLE);
    mac_clr_d   = (state_d == CLEAR);
    mac_en_d    = (state_d == TAP);
    coef_addr_d = (state_d == TAP) ? gen_coef : '0;
    smp_addr_d  = (state_d == TAP) ? gen_smp  : '0;
    mac_zero_d  = (state_d == TAP) & gen_zero;
    last_tap_d  = (state_d == TAP) & gen_last;
    res_wr_d    = (state_d == WRITE);
    res_addr_d  = (state_d == WRITE) ? n_d : '0;
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      wsp_q       <= '0;
      prb_q       <= '0;
      k_q         <= '0;
      n_q         <= '0;
      drain_q     <= '0;
      last_tap_q  <= 1'b0;
      pracuje_q   <= 1'b0;
      done_q      <= 1'b0;
      coef_addr_q <= '0;
      smp_addr_q  <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_zero_q  <= 1'b0;
      res_wr_q    <= 1'b0;
      res_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= Start;
      wsp_q       <= wsp_d;
      prb_q       <= prb_d;
      k_q         <= k_d;
      n_q         <= n_d;
      drain_q     <= drain_d;
      last_tap_q  <= last_tap_d;
      pracuje_q   <= pracuje_d;
      done_q      <= done_d;
      coef_addr_q <= coef_addr_d;
      smp_addr_q  <= smp_addr_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      mac_zero_q  <= mac_zero_d;
      res_wr_q    <= res_wr_d;
      res_addr_q  <= res_addr_d;
    end
  end

  assign Pracuje   = pracuje_q;
  assign DONE      = done_q;
  assign coef_addr = coef_addr_q;
  assign smp_addr  = smp_addr_q;
  assign mac_clr   = mac_clr_q;
  assign mac_en    = mac_en_q;
  assign mac_zero  = mac_zero_q;
  assign res_wr    = res_wr_q;
  assign res_addr  = res_addr_q;

endmodule
